// File: rtl/priority_dispatcher_pkg.sv
// Shared constants and helpers for the priority dispatcher and its per-destination queues.
// A queue entry stores the critical flag in the bit directly above the payload.
package priority_dispatcher_pkg;

  localparam int DEFAULT_REQUEST_WIDTH    = 64;
  localparam int DEFAULT_NUM_REQUEST      = 3;
  localparam int DEFAULT_QUEUE_SIZE       = 4;
  localparam int DEFAULT_CRITICAL_RESERVE = 1;
  localparam int DEFAULT_DROP_COUNT_WIDTH = 16;

  localparam int QUEUE_PTR_WIDTH = $clog2(DEFAULT_QUEUE_SIZE);
  localparam int QUEUE_CNT_WIDTH = QUEUE_PTR_WIDTH + 1;

  function automatic int queue_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int entry_width(input int payload_width);
    return payload_width + 1;
  endfunction

  function automatic int entry_crit_bit(input int payload_width);
    return payload_width;
  endfunction

endpackage

// File: rtl/priority_dispatcher_dispatch_queue.sv
// Circular buffer for one destination port. The head and its valid flag are
// registered from next-state values so the outputs never depend combinationally on inputs.
module dispatch_queue
  import priority_dispatcher_pkg::*;
#(
  parameter int ENTRY_WIDTH = entry_width(DEFAULT_REQUEST_WIDTH),
  parameter int DEPTH       = DEFAULT_QUEUE_SIZE,
  parameter int PTR_WIDTH   = QUEUE_PTR_WIDTH,
  parameter int CNT_WIDTH   = QUEUE_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_in,
  input  logic [ENTRY_WIDTH-1:0] push_entry_in,
  input  logic                   pop_in,
  output logic                   head_valid_out,
  output logic [ENTRY_WIDTH-1:0] head_entry_out,
  output logic [CNT_WIDTH-1:0]   occupancy_out
);

  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
  logic [ENTRY_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   head_valid_q, head_valid_d;
  logic [ENTRY_WIDTH-1:0] head_q, head_d;
  logic                   do_push;
  logic                   do_pop;

  // An ack on an empty port is ignored; the full check is only a safety net.
  always_comb begin
    do_pop   = pop_in & head_valid_q;
    do_push  = push_in & (count_q < CNT_WIDTH'(DEPTH));
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    head_valid_d = (count_d != '0);
    head_d       = head_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign head_valid_out = head_valid_q;
  assign head_entry_out = head_q;
  assign occupancy_out  = count_q;

endmodule

// File: rtl/priority_dispatcher.sv
// Fans one request stream out to per-destination queues; critical requests may use
// reserved entries, multicast is all-or-nothing, and empty-mask requests are dropped and counted.
module priority_dispatcher
  import priority_dispatcher_pkg::*;
#(
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = DEFAULT_REQUEST_WIDTH,
  parameter int NUM_REQUEST                  = DEFAULT_NUM_REQUEST,
  parameter int OUTPUT_QUEUE_SIZE            = DEFAULT_QUEUE_SIZE,
  parameter int CRITICAL_RESERVE             = DEFAULT_CRITICAL_RESERVE,
  parameter int DROP_COUNT_WIDTH             = DEFAULT_DROP_COUNT_WIDTH
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_in,
  input  logic                                                request_valid_in,
  input  logic                                                request_critical_in,
  input  logic [NUM_REQUEST-1:0]                              request_destination_mask_in,
  output logic                                                issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_out,
  output logic [NUM_REQUEST-1:0]                              request_valid_flatted_out,
  output logic [NUM_REQUEST-1:0]                              request_critical_flatted_out,
  input  logic [NUM_REQUEST-1:0]                              issue_ack_flatted_in,
  output logic [DROP_COUNT_WIDTH-1:0]                         drop_count_out
);

  localparam int W        = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int PTR_W    = queue_ptr_width(OUTPUT_QUEUE_SIZE);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENTRY_W  = entry_width(W);
  localparam int CRIT_BIT = entry_crit_bit(W);

  localparam logic [CNT_W-1:0] NORMAL_LIMIT = CNT_W'(OUTPUT_QUEUE_SIZE - CRITICAL_RESERVE);
  localparam logic [CNT_W-1:0] FULL_LIMIT   = CNT_W'(OUTPUT_QUEUE_SIZE);

  logic [CNT_W-1:0]            occupancy [NUM_REQUEST];
  logic [ENTRY_W-1:0]          head_entry [NUM_REQUEST];
  logic [NUM_REQUEST-1:0]      room;
  logic [NUM_REQUEST-1:0]      push;
  logic [ENTRY_W-1:0]          push_entry;
  logic                        mask_empty;
  logic                        all_room;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

  // Room looks at current occupancy only, so a same-cycle pop never frees space for a push.
  always_comb begin
    for (int i = 0; i < NUM_REQUEST; i++) begin
      room[i] = request_critical_in ? (occupancy[i] < FULL_LIMIT)
                                    : (occupancy[i] < NORMAL_LIMIT);
    end
    mask_empty    = (request_destination_mask_in == '0);
    all_room      = &(room | ~request_destination_mask_in);
    issue_ack_out = request_valid_in & ~reset_in & (mask_empty | all_room);
    push          = issue_ack_out ? request_destination_mask_in : '0;
    push_entry    = {request_critical_in, request_in};
    drop_count_d  = drop_count_q;
    if (issue_ack_out && mask_empty && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count_out = drop_count_q;

  for (genvar g = 0; g < NUM_REQUEST; g++) begin : g_port
    dispatch_queue #(
      .ENTRY_WIDTH (ENTRY_W),
      .DEPTH       (OUTPUT_QUEUE_SIZE),
      .PTR_WIDTH   (PTR_W),
      .CNT_WIDTH   (CNT_W)
    ) u_queue (
      .clk            (clk_in),
      .rst            (reset_in),
      .push_in        (push[g]),
      .push_entry_in  (push_entry),
      .pop_in         (issue_ack_flatted_in[g]),
      .head_valid_out (request_valid_flatted_out[g]),
      .head_entry_out (head_entry[g]),
      .occupancy_out  (occupancy[g])
    );

    assign request_flatted_out[g*W +: W]   = head_entry[g][W-1:0];
    assign request_critical_flatted_out[g] = head_entry[g][CRIT_BIT];
  end

endmodule

// File: tb/tb_priority_dispatcher.sv
// Self-checking bench for priority_dispatcher: a stimulus table with expected acks,
// per-port scoreboard queues for head contents, and hand-written reset/saturation/random sequences.
module tb_priority_dispatcher;

  localparam int W     = 64;
  localparam int N     = 3;
  localparam int QSIZE = 4;
  localparam int RES   = 1;
  localparam int DCW   = 4;
  localparam int DMAX  = (1 << DCW) - 1;

  logic           clk;
  logic           reset_in;
  logic [W-1:0]   request_in;
  logic           request_valid_in;
  logic           request_critical_in;
  logic [N-1:0]   request_destination_mask_in;
  logic           issue_ack_out;
  logic [W*N-1:0] request_flatted_out;
  logic [N-1:0]   request_valid_flatted_out;
  logic [N-1:0]   request_critical_flatted_out;
  logic [N-1:0]   issue_ack_flatted_in;
  logic [DCW-1:0] drop_count_out;

  priority_dispatcher #(
    .SINGLE_REQUEST_WIDTH_IN_BITS (W),
    .NUM_REQUEST                  (N),
    .OUTPUT_QUEUE_SIZE            (QSIZE),
    .CRITICAL_RESERVE             (RES),
    .DROP_COUNT_WIDTH             (DCW)
  ) dut (
    .clk_in                       (clk),
    .reset_in                     (reset_in),
    .request_in                   (request_in),
    .request_valid_in             (request_valid_in),
    .request_critical_in          (request_critical_in),
    .request_destination_mask_in  (request_destination_mask_in),
    .issue_ack_out                (issue_ack_out),
    .request_flatted_out          (request_flatted_out),
    .request_valid_flatted_out    (request_valid_flatted_out),
    .request_critical_flatted_out (request_critical_flatted_out),
    .issue_ack_flatted_in         (issue_ack_flatted_in),
    .drop_count_out               (drop_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic         crit;
    logic [N-1:0] mask;
    logic [W-1:0] payload;
    logic [N-1:0] pop;
    logic         exp_ack;
  } vec_t;

  vec_t        vecs [$];
  logic [W:0]  mq [N][$];
  int          exp_drops;
  int          tests_run;
  int          tests_failed;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input logic v, input logic c, input logic [N-1:0] m,
                         input logic [W-1:0] p, input logic [N-1:0] pop, input logic a);
    vec_t t;
    t.valid   = v;
    t.crit    = c;
    t.mask    = m;
    t.payload = p;
    t.pop     = pop;
    t.exp_ack = a;
    vecs.push_back(t);
  endtask

  function automatic logic model_ack(input logic v, input logic c, input logic [N-1:0] m);
    if (!v) return 1'b0;
    if (m == '0) return 1'b1;
    for (int i = 0; i < N; i++) begin
      if (m[i] && (mq[i].size() >= (c ? QSIZE : QSIZE - RES))) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic applyStimulus(input logic v, input logic c, input logic [N-1:0] m,
                               input logic [W-1:0] p, input logic [N-1:0] pop);
    request_valid_in            = v;
    request_critical_in         = c;
    request_destination_mask_in = m;
    request_in                  = p;
    issue_ack_flatted_in        = pop;
  endtask

  task automatic checkOutput(input string name, input logic exp_ack);
    logic [W+1:0] exp_head;
    check($sformatf("%s ack", name), 128'(issue_ack_out), 128'(exp_ack));
    for (int i = 0; i < N; i++) begin
      exp_head = (mq[i].size() == 0) ? '0 : {1'b1, mq[i][0]};
      check($sformatf("%s head%0d", name, i),
            128'({request_valid_flatted_out[i], request_critical_flatted_out[i],
                  request_flatted_out[i*W +: W]}),
            128'(exp_head));
    end
    check($sformatf("%s drops", name), 128'(drop_count_out), 128'(exp_drops));
  endtask

  task automatic model_update(input logic c, input logic [N-1:0] m, input logic [W-1:0] p,
                              input logic [N-1:0] pop, input logic acked);
    for (int i = 0; i < N; i++) begin
      if (pop[i] && mq[i].size() > 0) void'(mq[i].pop_front());
    end
    if (acked) begin
      if (m == '0) begin
        if (exp_drops < DMAX) exp_drops++;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m[i]) mq[i].push_back({c, p});
        end
      end
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, then commit the model at the edge.
  task automatic step(input logic v, input logic c, input logic [N-1:0] m, input logic [W-1:0] p,
                      input logic [N-1:0] pop, input logic exp_ack, input string name);
    applyStimulus(v, c, m, p, pop);
    @(negedge clk);
    checkOutput(name, exp_ack);
    @(posedge clk);
    model_update(c, m, p, pop, exp_ack);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic v, c, a;
    logic [N-1:0] m, pop;
    tests_run    = 0;
    tests_failed = 0;
    exp_drops    = 0;
    reset_in     = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    #1;
    check("reset ack forced low", 128'(issue_ack_out), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset valids", 128'(request_valid_flatted_out), 128'(0));
    check("reset payloads", 128'(request_flatted_out[127:0]), 128'(0));
    check("reset crit", 128'(request_critical_flatted_out), 128'(0));
    check("reset drops", 128'(drop_count_out), 128'(0));
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    reset_in = 1'b0;
    @(posedge clk);
    #1;

    // unicast to port 1
    add_vec(1, 0, 3'b010, 64'hA5, 3'b000, 1);
    add_vec(0, 0, 3'b000, 64'h0,  3'b000, 0);
    add_vec(0, 0, 3'b000, 64'h0,  3'b010, 0);
    add_vec(0, 0, 3'b000, 64'h0,  3'b000, 0);
    // reserve on port 0, then full with simultaneous pop
    add_vec(1, 0, 3'b001, 64'h01, 3'b000, 1);
    add_vec(1, 0, 3'b001, 64'h02, 3'b000, 1);
    add_vec(1, 0, 3'b001, 64'h03, 3'b000, 1);
    add_vec(1, 0, 3'b001, 64'h04, 3'b000, 0);
    add_vec(1, 1, 3'b001, 64'hC1, 3'b000, 1);
    add_vec(1, 1, 3'b001, 64'hC2, 3'b000, 0);
    add_vec(1, 1, 3'b001, 64'hC2, 3'b001, 0);
    add_vec(1, 1, 3'b001, 64'hC2, 3'b000, 1);
    repeat (4) add_vec(0, 0, 3'b000, 64'h0, 3'b001, 0);
    // multicast blocked by port 2
    add_vec(1, 0, 3'b100, 64'h21, 3'b000, 1);
    add_vec(1, 0, 3'b100, 64'h22, 3'b000, 1);
    add_vec(1, 0, 3'b100, 64'h23, 3'b000, 1);
    add_vec(1, 0, 3'b111, 64'h77, 3'b000, 0);
    add_vec(1, 0, 3'b111, 64'h77, 3'b100, 0);
    add_vec(1, 0, 3'b111, 64'h77, 3'b000, 1);
    add_vec(0, 0, 3'b000, 64'h0,  3'b111, 0);
    add_vec(0, 0, 3'b000, 64'h0,  3'b100, 0);
    add_vec(0, 0, 3'b000, 64'h0,  3'b100, 0);
    add_vec(0, 0, 3'b000, 64'h0,  3'b000, 0);
    // drops
    repeat (3) add_vec(1, 0, 3'b000, 64'hDD, 3'b000, 1);
    add_vec(0, 0, 3'b000, 64'h0, 3'b000, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].valid, vecs[k].crit, vecs[k].mask, vecs[k].payload,
           vecs[k].pop, vecs[k].exp_ack, $sformatf("vec%0d", k));
    end

    // drop counter saturation
    repeat (14) step(1'b1, 1'b0, 3'b000, 64'hEE, 3'b000, 1'b1, "drop sat");
    step(1'b0, 1'b0, 3'b000, 64'h0, 3'b000, 1'b0, "drop sat hold");

    // random traffic against the model
    for (int k = 0; k < 60; k++) begin
      v   = 1'($urandom_range(0, 1));
      c   = 1'($urandom_range(0, 1));
      m   = 3'($urandom_range(1, 7));
      pop = 3'($urandom_range(0, 7));
      a   = model_ack(v, c, m);
      step(v, c, m, 64'($urandom) << 32 | 64'($urandom), pop, a, $sformatf("rand%0d", k));
    end

    // asynchronous reset between edges while traffic is pending
    step(1'b1, 1'b0, 3'b001, 64'h11, 3'b000, model_ack(1'b1, 1'b0, 3'b001), "pre-rst a");
    step(1'b1, 1'b1, 3'b011, 64'h12, 3'b000, model_ack(1'b1, 1'b1, 3'b011), "pre-rst b");
    applyStimulus(1'b1, 1'b0, 3'b100, 64'h99, 3'b000);
    #2;
    reset_in = 1'b1;
    #1;
    check("async rst ack", 128'(issue_ack_out), 128'(0));
    check("async rst valids", 128'(request_valid_flatted_out), 128'(0));
    check("async rst crit", 128'(request_critical_flatted_out), 128'(0));
    check("async rst payloads", 128'(request_flatted_out[127:0]), 128'(0));
    check("async rst drops", 128'(drop_count_out), 128'(0));
    for (int i = 0; i < N; i++) mq[i].delete();
    exp_drops = 0;
    @(posedge clk);
    #2;
    check("rst held valids", 128'(request_valid_flatted_out), 128'(0));
    reset_in = 1'b0;
    step(1'b1, 1'b0, 3'b100, 64'h99, 3'b000, 1'b1, "post-rst push");
    step(1'b0, 1'b0, 3'b000, 64'h0,  3'b100, 1'b0, "post-rst head");
    step(1'b0, 1'b0, 3'b000, 64'h0,  3'b000, 1'b0, "post-rst empty");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/priority_dispatcher.md
Name: priority_dispatcher

Overview:
- One-to-many counterpart of the many-to-one priority arbiter: accepts a single request stream and delivers each request to one or more downstream consumers selected by a destination mask.
- One bounded queue per destination.
- Each queue reserves entries for critical requests, so a backed-up consumer cannot block critical traffic.
- Sits between a shared request source (e.g. an arbiter output) and per-client request ports; uses the same valid/ack handshake on both sides.

Parameters:
- SINGLE_REQUEST_WIDTH_IN_BITS, 64, payload width of one request.
- NUM_REQUEST, 3, number of destination ports.
- OUTPUT_QUEUE_SIZE, 4, entries per destination queue; power of 2, >= 2.
- CRITICAL_RESERVE, 1, entries per queue usable only by critical requests; 0 <= CRITICAL_RESERVE < OUTPUT_QUEUE_SIZE.
- DROP_COUNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk_in  input  1  clock; all state on rising edge.
- reset_in  input  1  reset; asynchronous, active-high.
- request_in  input  SINGLE_REQUEST_WIDTH_IN_BITS  upstream payload.
- request_valid_in  input  1  upstream request valid; held until acked.
- request_critical_in  input  1  request is critical.
- request_destination_mask_in  input  NUM_REQUEST  one-hot or multi-hot destination set; bit i = port i.
- issue_ack_out  output  1  combinational; request accepted (or dropped) at this rising edge.
- request_flatted_out  output  SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST  per-port head payload; port i at [i*W +: W].
- request_valid_flatted_out  output  NUM_REQUEST  per-port head valid.
- request_critical_flatted_out  output  NUM_REQUEST  per-port head critical flag.
- issue_ack_flatted_in  input  NUM_REQUEST  per-port consumer ack; pops head.
- drop_count_out  output  DROP_COUNT_WIDTH  count of requests dropped for an empty destination mask.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - all queues emptied and pointers cleared; request_valid_flatted_out=0; request_flatted_out=0; request_critical_flatted_out=0; drop_count_out=0.
  - issue_ack_out forced 0 while reset_in=1.
  - In-flight upstream request is not accepted and must be re-presented.
- Per-queue room:
  - room_normal[i] = occupancy[i] < OUTPUT_QUEUE_SIZE-CRITICAL_RESERVE.
  - room_crit[i] = occupancy[i] < OUTPUT_QUEUE_SIZE.
  - room[i] = request_critical_in ? room_crit[i] : room_normal[i].
- issue_ack_out = request_valid_in & ~reset_in & (mask==0 | all i with mask[i]=1 have room[i]).
- Accept (issue_ack_out=1, mask!=0):
  - At the edge, push {critical, payload} into every queue selected by the mask, simultaneously.
  - Multicast is all-or-nothing; there are no partial pushes.
- Drop (issue_ack_out=1, mask==0):
  - Nothing is enqueued.
  - drop_count_out increments and saturates at all-ones.
- Room is computed from current occupancy only; there is no same-cycle pop bypass. A full queue refuses a push even if its consumer acks in the same cycle.
- Latency: a request accepted at edge N is visible as head valid after edge N (cycle N+1) if the queue was empty. No combinational path from request_in to the outputs.
- Consumer side, per port i:
  - Head is presented while request_valid_flatted_out[i]=1.
  - issue_ack_flatted_in[i]=1 with valid=1 pops the head at that edge.
  - Ack while valid=0 is ignored.
  - Payload and critical outputs are all-zero when the port is empty.
- Simultaneous push and pop on a non-full queue: occupancy unchanged; ordering preserved.
- Strict FIFO order per port; critical requests do not overtake queued normal requests.
- Occupancy is NUM_REQUEST_LOG2-style width log2(OUTPUT_QUEUE_SIZE)+1; pointers wrap modulo OUTPUT_QUEUE_SIZE.
- Upstream may change request_* freely while issue_ack_out=0. Requests are never duplicated: one ack means one enqueue per destination.

Decomposition:
- Shared package:
  - QUEUE_PTR_WIDTH = $clog2(OUTPUT_QUEUE_SIZE).
  - QUEUE_CNT_WIDTH = QUEUE_PTR_WIDTH+1.
  - Entry layout constant: critical bit at MSB above the payload.
- One sub-module, dispatch_queue:
  - Async-reset circular buffer with push, pop, occupancy output, and registered head.
  - Instantiated NUM_REQUEST times.
- Top level contains only the room and ack logic and the drop counter.

Test Plan:
- Unicast: mask=3'b010, payload 0xA5, normal -> ack same cycle; port1 valid next cycle with 0xA5; ports 0 and 2 stay invalid; consumer ack -> port1 valid=0.
- Reserve: 3 normal to port0, consumer stalled -> 4th normal request not acked; then a critical request (0xC1) -> acked, occupancy 4; a further critical request -> not acked until one pop.
- Multicast blocking: port2 holds 3 normal entries, request mask=3'b111 normal -> no ack, no queue changes; pop port2 -> acked next edge, entry appears on all three ports.
- Drop: mask=0 valid for 3 consecutive acked cycles -> drop_count_out=3, all queues empty; force the counter to all-ones -> stays at all-ones.
- Full with simultaneous pop: port0 full, push critical and ack port0 in the same cycle -> pop occurs, push refused, occupancy 3; push accepted next cycle.
- Async reset mid-stream: queues partially filled, reset_in rises between edges -> all valids 0 immediately, issue_ack_out=0; after release, first request lands in an empty queue.
